// File: rtl/coord_scan_gen.sv
// Raster coordinate generator: walks an h_res x v_res grid in fixed-point steps,
// throttled by an in-flight credit count returned by the downstream pipeline.
module coord_scan_gen #(
  parameter int COORD_W      = 32,
  parameter int RES_W        = 16,
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT+1)
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               enable,
  input  logic [RES_W-1:0]   cfg_h_res,
  input  logic [RES_W-1:0]   cfg_v_res,
  input  logic [COORD_W-1:0] cfg_step,
  input  logic               cfg_continuous,
  output logic [COORD_W-1:0] coord_x,
  output logic [COORD_W-1:0] coord_y,
  output logic               coord_valid,
  input  logic               coord_ready,
  output logic               coord_sof,
  output logic               coord_eol,
  input  logic               ret_valid,
  output logic [CNT_W-1:0]   inflight,
  output logic               frame_done,
  output logic               err_underflow
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [RES_W-1:0]   h_res;
    logic [RES_W-1:0]   v_res;
    logic [COORD_W-1:0] step;
  } shadow_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  state_t           state, state_nxt;
  shadow_t          shd;
  logic [RES_W-1:0] col, row;
  logic [CNT_W-1:0] inflight_nxt;
  logic             hs, last_col, last_row, latch, drain_done, ret_ok;

  assign coord_valid = (state == RUN) && (inflight < MAX_CNT);
  assign hs          = coord_valid && coord_ready;
  assign last_col    = (col == shd.h_res - RES_W'(1));
  assign last_row    = (row == shd.v_res - RES_W'(1));
  assign coord_sof   = (state == RUN) && (col == '0) && (row == '0);
  assign coord_eol   = (state == RUN) && last_col;
  assign ret_ok      = ret_valid && (inflight != '0);

  // A return against an empty counter is dropped (flagged), never wraps the count.
  always_comb begin
    inflight_nxt = inflight;
    if (hs && !ret_ok)      inflight_nxt = inflight + CNT_W'(1);
    else if (!hs && ret_ok) inflight_nxt = inflight - CNT_W'(1);
  end

  always_comb begin
    state_nxt  = state;
    latch      = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: if (enable) begin
        state_nxt = RUN;
        latch     = 1'b1;
      end
      RUN: if (hs && last_col && last_row) state_nxt = DRAIN;
      DRAIN: if (inflight_nxt == '0) begin
        drain_done = 1'b1;
        if (cfg_continuous && enable) begin
          state_nxt = RUN;
          latch     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      shd           <= '0;
      col           <= '0;
      row           <= '0;
      coord_x       <= '0;
      coord_y       <= '0;
      inflight      <= '0;
      frame_done    <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      inflight      <= inflight_nxt;
      frame_done    <= drain_done;
      err_underflow <= err_underflow | (ret_valid && (inflight == '0));
      if (latch) begin
        shd.h_res <= (cfg_h_res == '0) ? RES_W'(1) : cfg_h_res;
        shd.v_res <= (cfg_v_res == '0) ? RES_W'(1) : cfg_v_res;
        shd.step  <= cfg_step;
        col       <= '0;
        row       <= '0;
        coord_x   <= '0;
        coord_y   <= '0;
      end else if (hs) begin
        // Final pixel leaves position untouched; DRAIN holds it.
        if (!last_col) begin
          col     <= col + RES_W'(1);
          coord_x <= coord_x + shd.step;
        end else if (!last_row) begin
          col     <= '0;
          coord_x <= '0;
          row     <= row + RES_W'(1);
          coord_y <= coord_y + shd.step;
        end
      end
    end
  end

endmodule

// File: tb/tb_coord_scan_gen.sv
// Directed bench for coord_scan_gen: a default-credit instance and a 2-credit
// instance share stimulus; each scenario checks the instance it targets.
module tb_coord_scan_gen;

  logic        aclk, areset, enable, cfg_continuous, coord_ready, ret_valid;
  logic [15:0] cfg_h_res, cfg_v_res;
  logic [31:0] cfg_step;

  logic [31:0] coord_x, coord_y, c_coord_x, c_coord_y;
  logic        coord_valid, coord_sof, coord_eol, frame_done, err_underflow;
  logic        c_coord_valid, c_coord_sof, c_coord_eol, c_frame_done, c_err_underflow;
  logic [3:0]  inflight;
  logic [1:0]  c_inflight;

  coord_scan_gen #(.MAX_INFLIGHT(8)) dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .cfg_h_res(cfg_h_res), .cfg_v_res(cfg_v_res), .cfg_step(cfg_step),
    .cfg_continuous(cfg_continuous),
    .coord_x(coord_x), .coord_y(coord_y), .coord_valid(coord_valid),
    .coord_ready(coord_ready), .coord_sof(coord_sof), .coord_eol(coord_eol),
    .ret_valid(ret_valid), .inflight(inflight), .frame_done(frame_done),
    .err_underflow(err_underflow)
  );

  coord_scan_gen #(.MAX_INFLIGHT(2)) dut_c (
    .aclk(aclk), .areset(areset), .enable(enable),
    .cfg_h_res(cfg_h_res), .cfg_v_res(cfg_v_res), .cfg_step(cfg_step),
    .cfg_continuous(cfg_continuous),
    .coord_x(c_coord_x), .coord_y(c_coord_y), .coord_valid(c_coord_valid),
    .coord_ready(coord_ready), .coord_sof(c_coord_sof), .coord_eol(c_coord_eol),
    .ret_valid(ret_valid), .inflight(c_inflight), .frame_done(c_frame_done),
    .err_underflow(c_err_underflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        sof;
    logic        eol;
  } pix_t;

  pix_t tab [0:22];
  int   hs_cyc [0:31];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1; enable = 1'b0; ret_valid = 1'b0; coord_ready = 1'b0;
    tick(); tick();
    areset = 1'b0;
    tick();
  endtask

  // Echoes every handshake as a return one cycle later; compares offered pixels to tab.
  task automatic run_scan(input int first, input int n, input int budget,
                          output int got, output int fd);
    logic prev_hs;
    prev_hs = 1'b0; got = 0; fd = 0;
    for (int c = 0; c < budget; c++) begin
      if (frame_done) fd++;
      ret_valid = prev_hs;
      prev_hs   = coord_valid && coord_ready;
      if (prev_hs && got < n) begin
        chk($sformatf("scan_x[%0d]", first+got),   coord_x,   tab[first+got].x);
        chk($sformatf("scan_y[%0d]", first+got),   coord_y,   tab[first+got].y);
        chk($sformatf("scan_sof[%0d]", first+got), coord_sof, tab[first+got].sof);
        chk($sformatf("scan_eol[%0d]", first+got), coord_eol, tab[first+got].eol);
        hs_cyc[got] = c;
        got++;
      end
      tick();
    end
    ret_valid = 1'b0;
  endtask

  initial begin
    int got, fd, cnt;
    logic [31:0] x0, y0;
    logic        s0;

    // Basic 4x3 frame, step 0x00200000
    tab[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    tab[1]  = '{32'h0020_0000, 32'h0000_0000, 1'b0, 1'b0};
    tab[2]  = '{32'h0040_0000, 32'h0000_0000, 1'b0, 1'b0};
    tab[3]  = '{32'h0060_0000, 32'h0000_0000, 1'b0, 1'b1};
    tab[4]  = '{32'h0000_0000, 32'h0020_0000, 1'b0, 1'b0};
    tab[5]  = '{32'h0020_0000, 32'h0020_0000, 1'b0, 1'b0};
    tab[6]  = '{32'h0040_0000, 32'h0020_0000, 1'b0, 1'b0};
    tab[7]  = '{32'h0060_0000, 32'h0020_0000, 1'b0, 1'b1};
    tab[8]  = '{32'h0000_0000, 32'h0040_0000, 1'b0, 1'b0};
    tab[9]  = '{32'h0020_0000, 32'h0040_0000, 1'b0, 1'b0};
    tab[10] = '{32'h0040_0000, 32'h0040_0000, 1'b0, 1'b0};
    tab[11] = '{32'h0060_0000, 32'h0040_0000, 1'b0, 1'b1};
    // Continuous: 4x2 step 1, then 2x1 (h changed to 2, v=0), then 2x1 again
    tab[12] = '{32'd0, 32'd0, 1'b1, 1'b0};
    tab[13] = '{32'd1, 32'd0, 1'b0, 1'b0};
    tab[14] = '{32'd2, 32'd0, 1'b0, 1'b0};
    tab[15] = '{32'd3, 32'd0, 1'b0, 1'b1};
    tab[16] = '{32'd0, 32'd1, 1'b0, 1'b0};
    tab[17] = '{32'd1, 32'd1, 1'b0, 1'b0};
    tab[18] = '{32'd2, 32'd1, 1'b0, 1'b0};
    tab[19] = '{32'd3, 32'd1, 1'b0, 1'b1};
    tab[20] = '{32'd0, 32'd0, 1'b1, 1'b0};
    tab[21] = '{32'd1, 32'd0, 1'b0, 1'b1};
    tab[22] = '{32'd0, 32'd0, 1'b1, 1'b0};

    cfg_h_res = 16'd4; cfg_v_res = 16'd3; cfg_step = 32'h0020_0000;
    cfg_continuous = 1'b0;
    do_reset();

    chk("rst_valid", coord_valid, 1'b0);
    chk("rst_x", coord_x, 32'h0);
    chk("rst_sof", coord_sof, 1'b0);
    chk("rst_inflight", inflight, 4'd0);
    chk("rst_err", err_underflow, 1'b0);

    // Basic scan; enable dropped after start must not abort the frame
    coord_ready = 1'b1;
    enable = 1'b1;
    chk("pre_start_valid", coord_valid, 1'b0);
    tick();
    enable = 1'b0;
    chk("first_valid_latency", coord_valid, 1'b1);
    run_scan(0, 12, 24, got, fd);
    chk("basic_count", got, 12);
    chk("basic_frame_done", fd, 1);
    chk("basic_final_y", coord_y, 32'h0040_0000);
    chk("basic_idle_valid", coord_valid, 1'b0);
    chk("basic_inflight", inflight, 4'd0);

    // Credit stall on the 2-credit instance
    do_reset();
    coord_ready = 1'b1; enable = 1'b1;
    tick();
    enable = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (c_coord_valid && coord_ready) cnt++;
      tick();
    end
    chk("credit_hs_count", cnt, 2);
    chk("credit_valid_low", c_coord_valid, 1'b0);
    chk("credit_inflight", c_inflight, 2'd2);
    ret_valid = 1'b1;
    tick();
    ret_valid = 1'b0;
    chk("credit_valid_back", c_coord_valid, 1'b1);
    chk("credit_inflight_dec", c_inflight, 2'd1);

    // Backpressure
    do_reset();
    coord_ready = 1'b0; enable = 1'b1;
    tick();
    enable = 1'b0;
    x0 = coord_x; y0 = coord_y; s0 = coord_sof;
    chk("bp_first_sof", s0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", coord_valid, 1'b1);
      chk("bp_x", coord_x, x0);
      chk("bp_y", coord_y, y0);
      chk("bp_sof", coord_sof, s0);
      chk("bp_inflight", inflight, 4'd0);
    end
    coord_ready = 1'b1;
    tick();
    chk("bp_release_x", coord_x, 32'h0020_0000);
    chk("bp_release_inflight", inflight, 4'd1);

    // Simultaneous handshake and return, then underflow
    ret_valid = 1'b1;
    tick();
    chk("simul_inflight", inflight, 4'd1);
    chk("simul_x", coord_x, 32'h0040_0000);
    coord_ready = 1'b0;
    tick();
    chk("ret_to_zero", inflight, 4'd0);
    chk("err_before", err_underflow, 1'b0);
    tick();
    ret_valid = 1'b0;
    chk("underflow_inflight", inflight, 4'd0);
    chk("underflow_err", err_underflow, 1'b1);
    tick(); tick();
    chk("underflow_sticky", err_underflow, 1'b1);

    // Continuous mode with mid-frame config change
    do_reset();
    cfg_h_res = 16'd4; cfg_v_res = 16'd2; cfg_step = 32'd1; cfg_continuous = 1'b1;
    coord_ready = 1'b1; enable = 1'b1;
    tick();
    cfg_h_res = 16'd2; cfg_v_res = 16'd0;
    run_scan(12, 11, 40, got, fd);
    chk("cont_count", got, 11);
    chk("cont_gap", hs_cyc[8] - hs_cyc[7], 2);
    chk("cont_gap2", hs_cyc[10] - hs_cyc[9], 2);
    chk("cont_frame_done", fd > 2, 1'b1);
    enable = 1'b0; cfg_continuous = 1'b0;

    // Reset mid-frame: 5 pixels issued, 2 returned
    cfg_h_res = 16'd4; cfg_v_res = 16'd3; cfg_step = 32'h0020_0000;
    do_reset();
    coord_ready = 1'b1; enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      ret_valid = (c == 2 || c == 3);
      tick();
    end
    ret_valid = 1'b0; coord_ready = 1'b0;
    chk("pre_rst_inflight", inflight, 4'd3);
    chk("pre_rst_x", coord_x, 32'h0020_0000);
    chk("pre_rst_y", coord_y, 32'h0020_0000);
    #2 areset = 1'b1;
    #1;
    chk("async_valid", coord_valid, 1'b0);
    chk("async_x", coord_x, 32'h0);
    chk("async_y", coord_y, 32'h0);
    chk("async_sof", coord_sof, 1'b0);
    chk("async_eol", coord_eol, 1'b0);
    chk("async_inflight", inflight, 4'd0);
    tick();
    areset = 1'b0;
    coord_ready = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_valid", coord_valid, 1'b0);
    chk("post_rst_sof", coord_sof, 1'b0);
    chk("post_rst_inflight", inflight, 4'd0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("reen_valid", coord_valid, 1'b1);
    chk("reen_x", coord_x, 32'h0);
    chk("reen_y", coord_y, 32'h0);
    chk("reen_sof", coord_sof, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
